shift_pipe: RTL and testbench
=============================

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits (legal range 1 or more).
REQ-002 Parameter DEPTH, default 2, number of register stages (legal range 1 or more).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  synchronous clear of all stage contents.
REQ-006 in_valid  input  1  upstream item present.
REQ-007 in_data  input  WIDTH  upstream item.
REQ-008 in_ready  output  1  pipe accepts in_data this cycle.
REQ-009 out_valid  output  1  stage DEPTH-1 holds an item.
REQ-010 out_data  output  WIDTH  item in stage DEPTH-1.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 count  output  CW  number of valid stages, where CW = clog2(DEPTH+1).

Function
REQ-013 Each stage i SHALL hold one data word and one valid bit; stage 0 is the input end and stage DEPTH-1 drives out_data and out_valid directly from registers.
REQ-014 Stage DEPTH-1 can accept SHALL be (not valid) or out_ready; stage i<DEPTH-1 can accept SHALL be (not valid) or (stage i+1 can accept).
REQ-015 in_ready SHALL equal stage 0 can accept; this is a combinational ready chain from out_ready with no registers in the path.
REQ-016 A transfer in SHALL occur on an edge where in_valid and in_ready are both 1; a transfer out SHALL occur on an edge where out_valid and out_ready are both 1.
REQ-017 When stage i can accept, it SHALL load the data and valid of stage i-1 (stage 0 loads in_data and the in_valid&in_ready term); otherwise it SHALL hold.
REQ-018 Bubbles SHALL collapse: an empty stage accepts the upstream item even when downstream is stalled.
REQ-019 Latency: an item accepted at edge N with no backpressure SHALL be on out_data with out_valid=1 after edge N+DEPTH-1.
REQ-020 With out_ready held at 1 and in_valid held at 1, throughput SHALL be one item per cycle with in_ready constantly 1.
REQ-021 Items SHALL leave in acceptance order, and none are dropped or duplicated.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 When the pipe is full and out_ready=0, in_ready SHALL be 0; if out_ready=1 on the same cycle, in_ready SHALL be 1 (simultaneous push and pop).
REQ-024 count SHALL equal the number of valid stages after each edge: +1 on push-only, -1 on pop-only, unchanged on push+pop or idle; range is 0..DEPTH.
REQ-025 flush=1 at an edge SHALL clear all valid bits and set count to 0, and SHALL take priority over any same-cycle push or pop; no transfer is counted.
REQ-026 Data registers of invalid stages are don't-care; out_data is meaningful only when out_valid=1.

Reset
REQ-027 When rstn=0 at a rising edge, all valid bits SHALL clear, count SHALL become 0, and out_valid SHALL become 0; rstn takes priority over flush and all transfers.
REQ-028 Data registers SHALL reset to 0 so that out_data reads 0 after reset.
REQ-029 Reset asserted mid-stream SHALL discard all held items; the first item after release follows REQ-019.
REQ-030 in_ready SHALL be 1 in the first cycle after rstn returns to 1.

Structure
REQ-031 Shared package shift_pipe_pkg SHALL hold the default WIDTH/DEPTH constants and the count-width function clog2(DEPTH+1).
REQ-032 One sub-module shift_pipe_stage (data+valid register with load/hold and synchronous clear) SHALL be instantiated DEPTH times by a generate loop; the ready chain and count live in the top.

Verification (WIDTH=8, DEPTH=3 unless stated)
REQ-033 Stream: push 0x11,0x22,0x33 on consecutive edges with out_ready=1 -> 0x11 appears after the 3rd edge (N+2), followed by 0x22 and 0x33 on successive cycles; in_ready stays 1; count peaks at 3.
REQ-034 Backpressure: out_ready=0 while pushing 0xA0..0xA4 -> 3 accepted, in_ready=0 thereafter, count=3, out_data holds 0xA0; raise out_ready -> 0xA0,0xA1,0xA2 exit in order.
REQ-035 Full push+pop: pipe full, in_valid=1 with 0x5C, out_ready=1 -> in_ready=1, count stays 3, 0x5C exits 3 pops later.
REQ-036 Bubble collapse: push 0x01, idle 2 cycles, push 0x02 with out_ready=0 -> both held in adjacent stages, count=2, pop order 0x01 then 0x02.
REQ-037 Flush vs push: count=2, flush=1 with in_valid=1 on the same edge -> count=0, out_valid=0, and the pushed item never appears.
REQ-038 Reset mid-stream and DEPTH=1 corner: rstn=0 with count=3 -> out_valid=0, out_data=0x00, count=0; with DEPTH=1, a push at edge N appears after edge N, and push+pop when full sustains one item per cycle.

Source files
------------

// File: rtl/shift_pipe_pkg.sv
// Shared constants and the count-width helper for the shift_pipe slice.
// The count needs clog2(DEPTH+1) bits so it can represent a completely full pipe.
package shift_pipe_pkg;

   localparam int DEFAULT_WIDTH = 8;
   localparam int DEFAULT_DEPTH = 2;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipe stage: a data word plus a valid bit, with load/hold and synchronous clear.
// Latency is one cycle on load; the stage holds its contents whenever load is low.
module shift_pipe_stage
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             clr,
   input  logic             load,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   // A clear drops only the valid bit; the data of an invalid stage is don't-care.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else if (clr) begin
         q_valid <= 1'b0;
      end else if (load) begin
         q_valid <= d_valid;
         q_data  <= d_data;
      end
   end

endmodule

// File: rtl/shift_pipe.sv
// Elastic DEPTH-stage register pipe with bubble collapse; latency DEPTH-1 edges after accept.
// in_ready is a purely combinational chain from out_ready, so a full pipe pushes and pops together.
module shift_pipe
   import shift_pipe_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic [WIDTH-1:0]              in_data,
   output logic                          in_ready,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              out_data,
   input  logic                          out_ready,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int CW = count_width(DEPTH);

   logic [DEPTH-1:0] stg_valid;
   logic [DEPTH-1:0] stg_accept;
   logic [WIDTH-1:0] stg_data [DEPTH];
   logic             push;
   logic             pop;

   // A stage can accept if it, or any stage downstream of it, is empty, or the output is draining.
   always_comb begin : ready_chain
      logic chain;
      chain      = out_ready;
      stg_accept = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         chain         = chain | ~stg_valid[i];
         stg_accept[i] = chain;
      end
   end

   assign in_ready  = stg_accept[0];
   assign push      = in_valid & in_ready;
   assign out_valid = stg_valid[DEPTH-1];
   assign out_data  = stg_data[DEPTH-1];
   assign pop       = out_valid & out_ready;

   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             ld_valid;
      logic [WIDTH-1:0] ld_data;

      if (g == 0) begin : g_head
         assign ld_valid = push;
         assign ld_data  = in_data;
      end else begin : g_body
         assign ld_valid = stg_valid[g-1];
         assign ld_data  = stg_data[g-1];
      end

      shift_pipe_stage #(
         .WIDTH (WIDTH)
      ) u_stage (
         .clk     (clk),
         .rstn    (rstn),
         .clr     (flush),
         .load    (stg_accept[g]),
         .d_valid (ld_valid),
         .d_data  (ld_data),
         .q_valid (stg_valid[g]),
         .q_data  (stg_data[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         count <= '0;
      end else if (flush) begin
         count <= '0;
      end else if (push && !pop) begin
         count <= count + CW'(1);
      end else if (pop && !push) begin
         count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_shift_pipe.sv
// Drives a DEPTH=3 and a DEPTH=1 shift_pipe with identical stimulus; each is scored
// against an in-order item model where an item becomes visible DEPTH-1 edges after acceptance.
module tb_shift_pipe;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       flush = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_ready = 1'b0;
   logic       chk_en = 1'b0;

   logic [1:0] rdy;
   logic [1:0] ov;
   logic [7:0] od [2];
   logic [1:0] cnt [2];
   logic [0:0] cnt1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   shift_pipe #(.WIDTH(8), .DEPTH(3)) u_dut3 (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (rdy[0]),
      .out_valid (ov[0]),
      .out_data  (od[0]),
      .out_ready (out_ready),
      .count     (cnt[0])
   );

   shift_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
      .clk       (clk),
      .rstn      (rstn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (rdy[1]),
      .out_valid (ov[1]),
      .out_data  (od[1]),
      .out_ready (out_ready),
      .count     (cnt1)
   );

   assign cnt[1] = {1'b0, cnt1};

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, got, want, $time);
      end
   endtask

   for (genvar k = 0; k < 2; k++) begin : g_chk
      localparam int D = (k == 0) ? 3 : 1;

      typedef struct {
         logic [7:0] data;
         int         age;
      } item_t;

      item_t      mq [$];
      logic [7:0] exp_q [$];

      // Reference model: in-order list of held items with their age in edges.
      initial forever begin
         @(negedge clk);
         #1;
         begin : model_step
            int   n;
            logic vis;
            logic rdy_m;
            logic pop_m;
            logic push_m;
            item_t it;
            n     = mq.size();
            vis   = (n > 0) && (mq[0].age >= D - 1);
            rdy_m = out_ready || (n < D);
            if (chk_en) begin
               chk($sformatf("d%0d_out_valid", D), {31'd0, ov[k]}, {31'd0, vis});
               chk($sformatf("d%0d_count", D), {30'd0, cnt[k]}, n);
               chk($sformatf("d%0d_in_ready", D), {31'd0, rdy[k]}, {31'd0, rdy_m});
               if (vis)
                  chk($sformatf("d%0d_out_data_head", D), {24'd0, od[k]}, {24'd0, mq[0].data});
            end
            if (!rstn || flush) begin
               mq.delete();
               exp_q.delete();
            end else begin
               pop_m  = vis && out_ready;
               push_m = in_valid && rdy_m;
               foreach (mq[j]) mq[j].age++;
               if (pop_m) void'(mq.pop_front());
               if (push_m) begin
                  it.data = in_data;
                  it.age  = 0;
                  mq.push_back(it);
                  exp_q.push_back(in_data);
               end
            end
         end
      end

      // Scoreboard monitor: every output handshake must deliver the next accepted item.
      initial forever begin
         @(negedge clk);
         #2;
         if (chk_en && rstn && !flush && ov[k] === 1'b1 && out_ready) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("d%0d_pop_unexpected", D), {31'd0, ov[k]}, 32'd0);
            end else begin
               logic [7:0] want;
               want = exp_q.pop_front();
               chk($sformatf("d%0d_pop_data", D), {24'd0, od[k]}, {24'd0, want});
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic [7:0] d, input logic ordy,
                      input logic fl = 1'b0, input logic rs = 1'b1);
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rstn      = rs;
   endtask

   initial begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      chk_en = 1'b1;
      #1;
      chk("reset_out_data_d3", {24'd0, od[0]}, 32'd0);
      chk("reset_out_data_d1", {24'd0, od[1]}, 32'd0);

      // Stream
      cyc(1'b1, 8'h11, 1'b1);
      cyc(1'b1, 8'h22, 1'b1);
      cyc(1'b1, 8'h33, 1'b1);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);

      // Backpressure
      for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA0 + 8'(i), 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);

      // Full push+pop
      cyc(1'b1, 8'h51, 1'b0);
      cyc(1'b1, 8'h52, 1'b0);
      cyc(1'b1, 8'h53, 1'b0);
      cyc(1'b1, 8'h5C, 1'b1);
      repeat (5) cyc(1'b0, 8'h00, 1'b1);

      // Bubble collapse
      cyc(1'b1, 8'h01, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      cyc(1'b1, 8'h02, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);

      // Flush vs push
      cyc(1'b1, 8'h61, 1'b0);
      cyc(1'b1, 8'h62, 1'b0);
      cyc(1'b1, 8'hEE, 1'b0, 1'b1);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);

      // Reset mid-stream
      cyc(1'b1, 8'hC1, 1'b0);
      cyc(1'b1, 8'hC2, 1'b0);
      cyc(1'b1, 8'hC3, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0);
      #1;
      chk("midreset_out_data_d3", {24'd0, od[0]}, 32'd0);
      chk("midreset_out_data_d1", {24'd0, od[1]}, 32'd0);
      cyc(1'b1, 8'h77, 1'b1);
      repeat (4) cyc(1'b0, 8'h00, 1'b1);

      // Sustained full-rate streaming
      for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h80 + i), 1'b1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
             $urandom_range(0, 49) == 0, $urandom_range(0, 99) != 0);
      end

      repeat (8) cyc(1'b0, 8'h00, 1'b1);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
